// File: rtl/vc_pkg.sv
// Shared definitions for the vc reset/bring-up sequencer: state encoding and
// a counter-width helper.
package vc_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_REL     = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = $clog2(n);
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/vc_reset_seq_wdt.sv
// Watchdog counter: counts while running, cleared by a kick, and pulses
// timeout_o on the cycle whose edge must re-sequence the design.
module vc_wdt
    import vc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic kick_i,
    output logic timeout_o
);

    localparam int unsigned W = clog2(TIMEOUT);

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_limit;

    assign at_limit  = (cnt_q == W'(TIMEOUT - 1));
    assign timeout_o = run_i && at_limit && !kick_i;

    // A kick wins over a timeout landing on the same cycle.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run_i || kick_i || at_limit) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vc_reset_seq.sv
// Staged reset release for the vc subsystem: stretch, ordered per-domain
// release, boot-strap capture, run-time heartbeat and optional watchdog.
module vc_reset_seq
    import vc_pkg::*;
#(
    parameter int unsigned NCH         = 3,
    parameter int unsigned STRETCH     = 16,
    parameter int unsigned GAP         = 4,
    parameter int unsigned NSTRAP      = 2,
    parameter int unsigned MAX_COUNT   = 10_000_000,
    parameter int unsigned WDT_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic [NSTRAP-1:0] strap,
    input  logic              wdt_kick,
    output logic [NCH-1:0]    rst_out,
    output logic [NSTRAP-1:0] mode,
    output logic              ready,
    output logic              hb,
    output logic              wdt_fired
);

    localparam int unsigned CW = clog2((STRETCH > GAP) ? STRETCH : GAP);
    localparam int unsigned IW = clog2(NCH);
    localparam int unsigned HW = clog2(MAX_COUNT);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [HW-1:0]     hb_cnt_q, hb_cnt_d;
    logic [NCH-1:0]    rst_out_q, rst_out_d;
    logic [NSTRAP-1:0] mode_q, mode_d;
    logic              ready_q, ready_d;
    logic              hb_q, hb_d;
    logic              wdt_fired_q, wdt_fired_d;
    logic              wdt_timeout;

    generate
        if (WDT_TIMEOUT > 0) begin : g_wdt
            vc_wdt #(.TIMEOUT(WDT_TIMEOUT)) u_wdt (
                .clk       (clk),
                .reset     (reset),
                .run_i     ((state_q == ST_RUN) && ena),
                .kick_i    (wdt_kick),
                .timeout_o (wdt_timeout)
            );
        end else begin : g_no_wdt
            logic unused_kick;
            assign unused_kick = wdt_kick;
            assign wdt_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        hb_cnt_d    = hb_cnt_q;
        rst_out_d   = rst_out_q;
        mode_d      = mode_q;
        ready_d     = ready_q;
        hb_d        = hb_q;
        wdt_fired_d = wdt_fired_q;

        // ena low forces HOLD from anywhere but keeps mode and the sticky flag.
        if (!ena) begin
            state_d   = ST_HOLD;
            cnt_d     = '0;
            idx_d     = '0;
            hb_cnt_d  = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
            hb_d      = 1'b0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end
                ST_STRETCH: begin
                    if (cnt_q == CW'(STRETCH - 1)) begin
                        cnt_d        = '0;
                        mode_d       = strap;
                        rst_out_d[0] = 1'b0;
                        if (NCH == 1) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = ST_REL;
                            idx_d   = IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_REL: begin
                    if (cnt_q == CW'(GAP - 1)) begin
                        cnt_d = '0;
                        for (int unsigned i = 0; i < NCH; i++) begin
                            if (idx_q == IW'(i)) begin
                                rst_out_d[i] = 1'b0;
                            end
                        end
                        if (idx_q == IW'(NCH - 1)) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wdt_timeout) begin
                        state_d     = ST_HOLD;
                        idx_d       = '0;
                        hb_cnt_d    = '0;
                        rst_out_d   = '1;
                        ready_d     = 1'b0;
                        hb_d        = 1'b0;
                        wdt_fired_d = 1'b1;
                    end else if (hb_cnt_q == HW'(MAX_COUNT - 1)) begin
                        hb_cnt_d = '0;
                        hb_d     = ~hb_q;
                    end else begin
                        hb_cnt_d = hb_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            hb_cnt_q    <= '0;
            rst_out_q   <= '1;
            mode_q      <= '0;
            ready_q     <= 1'b0;
            hb_q        <= 1'b0;
            wdt_fired_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            hb_cnt_q    <= hb_cnt_d;
            rst_out_q   <= rst_out_d;
            mode_q      <= mode_d;
            ready_q     <= ready_d;
            hb_q        <= hb_d;
            wdt_fired_q <= wdt_fired_d;
        end
    end

    assign rst_out   = rst_out_q;
    assign mode      = mode_q;
    assign ready     = ready_q;
    assign hb        = hb_q;
    assign wdt_fired = wdt_fired_q;

endmodule

// File: tb/tb_vc_reset_seq.sv
// Scoreboard bench for vc_reset_seq: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_vc_reset_seq;

    localparam logic [4:0] M_RST  = 5'b00001;
    localparam logic [4:0] M_RDY  = 5'b00010;
    localparam logic [4:0] M_MODE = 5'b00100;
    localparam logic [4:0] M_HB   = 5'b01000;
    localparam logic [4:0] M_WF   = 5'b10000;
    localparam logic [4:0] M_ALL  = 5'b11111;

    typedef struct {
        int         cyc;
        logic [4:0] m;
        logic [2:0] rst;
        logic       rdy;
        logic [1:0] mode;
        logic       hb;
        logic       wf;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, ena, wdt_kick;
    logic [1:0] strap;
    logic [2:0] rst_out;
    logic [1:0] mode;
    logic       ready, hb, wdt_fired;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    vc_reset_seq #(
        .NCH(3), .STRETCH(4), .GAP(2), .NSTRAP(2), .MAX_COUNT(5), .WDT_TIMEOUT(20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .strap     (strap),
        .wdt_kick  (wdt_kick),
        .rst_out   (rst_out),
        .mode      (mode),
        .ready     (ready),
        .hb        (hb),
        .wdt_fired (wdt_fired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [4:0] m, input logic [2:0] r, input logic rd,
                        input logic [1:0] md, input logic h, input logic w, input string tag);
        exp_t e;
        e.cyc = c; e.m = m; e.rst = r; e.rdy = rd; e.mode = md; e.hb = h; e.wf = w; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp_v);
        end
    endtask

    // After edge n the monitor sees cyc == n.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s stale: expected at cyc %0d, now %0d", e.tag, e.cyc, cyc);
            end else begin
                if (e.m[0]) chk({e.tag, ".rst_out"}, rst_out, e.rst);
                if (e.m[1]) chk({e.tag, ".ready"}, {2'b00, ready}, {2'b00, e.rdy});
                if (e.m[2]) chk({e.tag, ".mode"}, {1'b0, mode}, {1'b0, e.mode});
                if (e.m[3]) chk({e.tag, ".hb"}, {2'b00, hb}, {2'b00, e.hb});
                if (e.m[4]) chk({e.tag, ".wdt_fired"}, {2'b00, wdt_fired}, {2'b00, e.wf});
            end
        end
    end

    // Inputs change 1 time unit after edge c, so edge c+1 is the first to see them.
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    int e0, r, e1, r2, e2, e3;

    initial begin
        reset = 1'b1; ena = 1'b1; strap = 2'b10; wdt_kick = 1'b0;
        push(1, M_ALL, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, "reset1");
        push(2, M_ALL, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, "reset2");

        e0 = 4;
        r  = e0 + 8;
        e1 = r + 71;
        r2 = e1 + 8;
        e2 = r2 + 6;
        e3 = e2 + 7;

        for (int k = 0; k < 4; k++)
            push(e0 + k, M_RST | M_RDY, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, "stretch");
        push(e0 + 4, M_RST | M_RDY | M_MODE, 3'b110, 1'b0, 2'b10, 1'b0, 1'b0, "rel0");
        push(e0 + 5, M_RST, 3'b110, 1'b0, 2'b00, 1'b0, 1'b0, "rel0_hold");
        push(e0 + 6, M_RST | M_RDY, 3'b100, 1'b0, 2'b00, 1'b0, 1'b0, "rel1");
        push(e0 + 7, M_RST | M_RDY, 3'b100, 1'b0, 2'b00, 1'b0, 1'b0, "rel1_hold");
        push(r, M_ALL, 3'b000, 1'b1, 2'b10, 1'b0, 1'b0, "run_entry");
        push(r + 4,  M_HB, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, "hb_r4");
        push(r + 5,  M_HB, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0, "hb_r5");
        push(r + 9,  M_HB, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0, "hb_r9");
        push(r + 10, M_HB, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, "hb_r10");
        push(r + 14, M_HB, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, "hb_r14");
        push(r + 15, M_HB | M_MODE, 3'b000, 1'b1, 2'b10, 1'b1, 1'b0, "hb_r15");
        push(r + 25, M_RST | M_RDY | M_WF, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, "kicked_run");
        push(r + 49, M_RST | M_WF, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, "pre_collide");
        push(r + 50, M_RST | M_RDY | M_WF, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, "collide");
        push(r + 51, M_RST | M_RDY | M_WF, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, "post_collide");
        push(r + 69, M_RST | M_HB | M_WF, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0, "pre_fire");
        push(r + 70, M_RST | M_RDY | M_HB | M_WF, 3'b111, 1'b0, 2'b00, 1'b0, 1'b1, "wdt_fire");
        push(e1 + 3, M_RST | M_MODE | M_WF, 3'b111, 1'b0, 2'b10, 1'b0, 1'b1, "re_stretch");
        push(e1 + 4, M_RST | M_MODE, 3'b110, 1'b0, 2'b01, 1'b0, 1'b1, "re_rel0");
        push(e1 + 6, M_RST, 3'b100, 1'b0, 2'b00, 1'b0, 1'b1, "re_rel1");
        push(e1 + 7, M_RST | M_RDY, 3'b100, 1'b0, 2'b00, 1'b0, 1'b1, "re_rel1_hold");
        push(r2, M_RST | M_RDY | M_WF, 3'b000, 1'b1, 2'b00, 1'b0, 1'b1, "re_run");
        push(r2 + 3, M_ALL, 3'b111, 1'b0, 2'b01, 1'b0, 1'b1, "ena_drop");
        push(e2 + 4, M_RST | M_MODE | M_WF, 3'b110, 1'b0, 2'b11, 1'b0, 1'b1, "abort_rel0");
        push(e2 + 5, M_RST | M_RDY | M_MODE, 3'b111, 1'b0, 2'b11, 1'b0, 1'b1, "abort");
        push(e3 + 3, M_RST | M_MODE, 3'b111, 1'b0, 2'b11, 1'b0, 1'b1, "restart_stretch");
        push(e3 + 4, M_RST | M_MODE, 3'b110, 1'b0, 2'b00, 1'b0, 1'b1, "restart_rel0");
        push(e3 + 6, M_RST, 3'b100, 1'b0, 2'b00, 1'b0, 1'b1, "restart_rel1");
        push(e3 + 8, M_RST | M_RDY | M_WF, 3'b000, 1'b1, 2'b00, 1'b0, 1'b1, "restart_run");
        push(e3 + 10, M_ALL, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, "final_reset");

        wait_until(e0 - 1); reset = 1'b0;
        wait_until(e0 + 4); strap = 2'b01;

        // Kicks at edges r+10, r+20, r+30, then r+50 lands on the timeout cycle.
        for (int k = 1; k <= 5; k++) begin
            if (k != 4) begin
                wait_until(r + 10 * k - 1); wdt_kick = 1'b1;
                wait_until(r + 10 * k);     wdt_kick = 1'b0;
            end
        end

        wait_until(r2 + 2); ena = 1'b0;
        wait_until(r2 + 5); ena = 1'b1; strap = 2'b11;
        wait_until(e2 + 4); ena = 1'b0; strap = 2'b00;
        wait_until(e2 + 6); ena = 1'b1;
        wait_until(e3 + 9); reset = 1'b1;
        wait_until(e3 + 12);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vc_reset_seq.md
Name: vc_reset_seq

Overview:
Parametrised reset/bring-up sequencer between the TinyTapeout top wrapper and the vc CPU subsystem. It replaces the single registered reset with NCH staged, ordered reset releases, and captures boot-mode straps at release. It also adds a run-time heartbeat and a watchdog that re-sequences the design on timeout. One instance sits in the top wrapper, fed by the registered ~rst_n and ena.

Parameters:
NCH, 3, number of reset domains, released in index order (>=1)
STRETCH, 16, cycles held in reset after external reset/ena are clean (>=1)
GAP, 4, cycles between successive domain releases (>=1)
NSTRAP, 2, width of boot-mode strap capture (>=1)
MAX_COUNT, 24'd10_000_000, heartbeat half-period in cycles (>=2)
WDT_TIMEOUT, 0, watchdog timeout in cycles; 0 disables the watchdog

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ena  in  1  design enable; low is treated as reset
strap  in  NSTRAP  boot-mode straps (driven from ui_in bits)
wdt_kick  in  1  watchdog restart pulse from the CPU
rst_out  out  NCH  per-domain active-high reset; bit i is domain i
mode  out  NSTRAP  strap value captured at release of domain 0
ready  out  1  all domains released
hb  out  1  heartbeat square wave
wdt_fired  out  1  sticky flag: a watchdog reset has occurred

Behaviour:
- Reset is fixed: one clock, synchronous, active-high; all outputs are registered.
- Values on reset: rst_out=all ones, mode=0, ready=0, hb=0, wdt_fired=0, state=HOLD, all counters 0.
- States:
  - HOLD: entered on reset or !ena, from any state, taking effect at the next edge. rst_out=all ones, ready=0, hb=0.
  - STRETCH: entered from HOLD at the edge E0, the first edge where reset=0 and ena=1.
  - REL: releases domains one at a time.
  - RUN: all domains released.
- STRETCH: counts 0..STRETCH-1. At edge E0+STRETCH: mode<=strap, rst_out[0]<=0, go to REL with idx=1. If NCH=1, go to RUN instead.
- REL: rst_out[i] deasserts at edge E0+STRETCH+i*GAP. Once released, a domain stays released until HOLD. At the edge releasing rst_out[NCH-1]: ready<=1, go to RUN.
- RUN, heartbeat: hb toggles every MAX_COUNT cycles; the counter wraps at MAX_COUNT-1. The first toggle is MAX_COUNT cycles after entering RUN. Leaving RUN clears hb and the counter.
- RUN, watchdog (WDT_TIMEOUT>0):
  - The counter increments each RUN cycle; wdt_kick=1 clears it to 0, and kick wins over the timeout on the same cycle.
  - When the counter reaches WDT_TIMEOUT-1 without a kick, the next edge enters HOLD for exactly one cycle and sets wdt_fired<=1. The block then re-sequences via STRETCH exactly as from E0.
  - wdt_kick is ignored outside RUN.
  - wdt_fired is cleared only by reset. It is not cleared by an ena drop, which holds the block in HOLD but preserves the flag.
- mode is held through HOLD and updated only at each domain-0 release.
- Reset or ena drop mid-STRETCH/REL: all of rst_out reasserts at the next edge and the sequence restarts from scratch.
- Counter widths are $clog2 of their limit, with at least 1 bit; no overflow beyond the limit is possible.

Decomposition:
- Shared package vc_pkg: state encoding localparams (HOLD=2'd0, STRETCH=2'd1, REL=2'd2, RUN=2'd3) and a clog2 helper function.
- One natural sub-module: vc_wdt, the watchdog counter with kick/timeout pulse output. It is instantiated only when WDT_TIMEOUT>0.
- Heartbeat and sequencing stay in vc_reset_seq.
- The top wrapper replaces its r_reset fan-out with rst_out[0] to the cpu and the other bits to peripherals.

Test Plan:
All tests use NCH=3, STRETCH=4, GAP=2, NSTRAP=2, MAX_COUNT=5, WDT_TIMEOUT=20.
- Power-up: reset=1 for 3 cycles, then 0 with ena=1 and strap=2'b10 -> rst_out=111 through E0+3; rst_out=110 at E0+4, 100 at E0+6, 000 and ready=1 at E0+8; mode=2'b10.
- Strap capture: strap changes 2'b10->2'b01 at E0+5 -> mode stays 2'b10.
- Heartbeat: in RUN with kicks every 10 cycles -> hb toggles at RUN+5, +10, +15; period 10.
- Watchdog timeout: no kick -> 20 cycles into RUN, rst_out=111 for one cycle and wdt_fired=1. Re-release follows the same 4/2/2 timing. wdt_fired stays 1 through a subsequent ena low/high.
- Kick/timeout collision: wdt_kick=1 on the timeout cycle -> no HOLD entry and wdt_fired stays 0.
- Mid-sequence abort: ena=0 at E0+5 (rst_out=110) -> rst_out=111 and ready=0 at the next edge. ena=1 again -> full restart with rst_out[0] released 4 cycles later.
